// File: rtl/cpu_run_monitor.sv
// Run-control and retirement monitor for the single-cycle core: sequences the core reset,
// bounds the run by halt (PC self-loop) or cycle budget, and keeps a circular write-back trace.
`timescale 1ns/1ps
module cpu_run_monitor #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 16,
  parameter int MAX_CYCLES  = 1000,
  parameter int RESET_HOLD  = 3,
  parameter int HALT_REPEAT = 2,
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1),
  localparam int IDX_W      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic [ADDR_W-1:0] pc,
  input  logic [DATA_W-1:0] writeData,
  input  logic              wen,
  output logic              cpu_nrst,
  output logic              running,
  output logic              done,
  output logic              halted,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [IDX_W:0]    trace_count,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [ADDR_W-1:0] rd_pc,
  output logic [DATA_W-1:0] rd_data
);

  localparam int MW = $clog2(HALT_REPEAT + 1);
  localparam int HW = $clog2(RESET_HOLD + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HOLD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [IDX_W:0] FULL = (IDX_W + 1)'(DEPTH);

  logic [1:0]        state;
  logic [HW-1:0]     hold_cnt;
  logic [MW-1:0]     match_cnt;
  logic [MW-1:0]     match_next;
  logic [ADDR_W-1:0] prev_pc;
  logic              prev_valid;
  logic [IDX_W-1:0]  wptr;
  logic              halt_hit;
  logic              to_hit;

  logic [ADDR_W-1:0] trace_pc   [DEPTH];
  logic [DATA_W-1:0] trace_data [DEPTH];

  logic [IDX_W-1:0]  oldest;
  logic [IDX_W-1:0]  slot;
  logic              rd_valid;

  assign running  = (state == RUN);
  assign done     = (state == DONE);
  assign cpu_nrst = running;

  always_comb begin
    match_next = '0;
    if (prev_valid && (pc == prev_pc))
      match_next = match_cnt + MW'(1);
    halt_hit = (match_next == MW'(HALT_REPEAT));
    to_hit   = (cycle_count == CNT_W'(MAX_CYCLES - 1));
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      match_cnt   <= '0;
      prev_pc     <= '0;
      prev_valid  <= 1'b0;
      wptr        <= '0;
      cycle_count <= '0;
      trace_count <= '0;
      halted      <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= HOLD;
            hold_cnt    <= '0;
            match_cnt   <= '0;
            prev_pc     <= '0;
            prev_valid  <= 1'b0;
            wptr        <= '0;
            cycle_count <= '0;
            trace_count <= '0;
            halted      <= 1'b0;
            timeout     <= 1'b0;
          end
        end
        HOLD: begin
          if (hold_cnt == HW'(RESET_HOLD - 1)) state <= RUN;
          else                                 hold_cnt <= hold_cnt + HW'(1);
        end
        RUN: begin
          cycle_count <= cycle_count + CNT_W'(1);
          prev_pc     <= pc;
          prev_valid  <= 1'b1;
          match_cnt   <= match_next;
          if (wen) begin
            wptr <= wptr + IDX_W'(1);
            if (trace_count != FULL) trace_count <= trace_count + (IDX_W + 1)'(1);
          end
          // Halt takes priority when both conditions land on the same cycle.
          if (halt_hit || to_hit) begin
            state   <= DONE;
            halted  <= halt_hit;
            timeout <= to_hit && !halt_hit;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (running && wen) begin
      trace_pc[wptr]   <= pc;
      trace_data[wptr] <= writeData;
    end
  end

  always_comb begin
    oldest   = (trace_count == FULL) ? wptr : '0;
    slot     = oldest + rd_idx;
    rd_valid = ({1'b0, rd_idx} < trace_count);
    rd_pc    = rd_valid ? trace_pc[slot]   : '0;
    rd_data  = rd_valid ? trace_data[slot] : '0;
  end

endmodule
